// File: rtl/fadd_a1_pkg.sv
// Shared field layout and helpers for the a1 adder: {sign, exp[7:0], man[22:0]}.
// The mantissa carries its leading bit explicitly, so there is no hidden one.
package fadd_a1_pkg;

    localparam int         EXP_W   = 8;
    localparam int         MAN_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam int         BIAS    = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    function automatic logic get_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [MAN_W-1:0] get_man(input logic [31:0] v);
        return v[22:0];
    endfunction

    // Zero ignores the sign bit, so -0 counts as zero too.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/fadd_a1_unit_lzc23.sv
// 23-bit leading-zero counter; an all-zero input reports 23.
module lzc23
    import fadd_a1_pkg::*;
(
    input  logic [MAN_W-1:0] i_val,
    output logic [4:0]       o_cnt
);

    // NOTE: o_cnt gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_cnt = 5'd23;
        for (int i = 0; i < MAN_W; i++) begin
            if (i_val[i]) o_cnt = 5'(22 - i);
        end
    end

endmodule

// File: rtl/fadd_a1_unit.sv
// a1 datapath adder: combinational sum on out, registered copy on out_q.
// Truncating alignment, lzc-relative normalisation, flush-to-zero and NaN-payload overflow.
module fadd_a1_unit
    import fadd_a1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic [31:0] out_q
);

    fp_t               w_a, w_b, w_l, w_s;
    logic              w_a_is_l;
    logic [EXP_W-1:0]  w_d;
    logic [MAN_W-1:0]  w_ms_al;
    logic              w_same, w_mag_ge, w_cancel, w_sign;
    logic [MAN_W:0]    w_sum;
    logic [4:0]        w_lzc_sum, w_lzc_ml;
    logic signed [9:0] w_k, w_el_minus_k, w_exp;
    logic [MAN_W-1:0]  w_man;
    logic              w_underflow, w_overflow;
    logic [31:0]       r_out_q;

    assign w_a = fp_t'(a);
    assign w_b = fp_t'(b);

    // On a full tie either choice yields the same result, so A wins ties.
    assign w_a_is_l = (w_a.exp > w_b.exp) || ((w_a.exp == w_b.exp) && (w_a.man >= w_b.man));
    assign w_l      = w_a_is_l ? w_a : w_b;
    assign w_s      = w_a_is_l ? w_b : w_a;

    assign w_d      = w_l.exp - w_s.exp;
    assign w_ms_al  = (w_d >= 8'd23) ? '0 : (w_s.man >> w_d);

    // An unnormalised L can end up smaller than the aligned S, so the sign follows magnitude.
    assign w_same   = (w_l.sign == w_s.sign);
    assign w_mag_ge = (w_l.man >= w_ms_al);
    assign w_cancel = !w_same && (w_l.man == w_ms_al);
    assign w_sign   = (w_same || w_mag_ge) ? w_l.sign : w_s.sign;

    assign w_sum = w_same   ? ({1'b0, w_l.man} + {1'b0, w_ms_al}) :
                   w_mag_ge ? {1'b0, w_l.man - w_ms_al} :
                              {1'b0, w_ms_al - w_l.man};

    lzc23 u_lzc_sum (.i_val(w_sum[MAN_W-1:0]), .o_cnt(w_lzc_sum));
    lzc23 u_lzc_ml  (.i_val(w_l.man),          .o_cnt(w_lzc_ml));

    // k is relative to L's own leading-zero count, so unnormalised inputs are never promoted.
    assign w_k          = signed'({5'b0, w_lzc_sum}) - signed'({5'b0, w_lzc_ml});
    assign w_el_minus_k = signed'({2'b0, w_l.exp}) - w_k;

    always_comb begin
        w_man = w_sum[MAN_W-1:0];
        w_exp = signed'({2'b0, w_l.exp});
        if (w_sum[MAN_W]) begin
            w_man = w_sum[MAN_W:1];
            w_exp = signed'({2'b0, w_l.exp}) + 10'sd1;
        end else if (w_k > 10'sd0) begin
            w_man = w_sum[MAN_W-1:0] << w_k[4:0];
            w_exp = w_el_minus_k;
        end
    end

    assign w_underflow = !w_sum[MAN_W] && (w_el_minus_k < 10'sd1);
    assign w_overflow  = (w_exp >= 10'sd255);

    always_comb begin
        if (is_zero(b))       out = b ? a : a;
        else if (is_zero(a))  out = b;
        else if (w_cancel)    out = 32'h0000_0000;
        else if (w_underflow) out = {w_sign, 31'd0};
        else if (w_overflow)  out = {w_sign, EXP_MAX, 23'h0 - w_man};
        else                  out = {w_sign, w_exp[7:0], w_man};
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out_q <= 32'h0000_0000;
        else     r_out_q <= out;
    end

    assign out_q = r_out_q;

endmodule

// File: tb/tb_fadd_a1_unit.sv
// Directed-vector bench for fadd_a1_unit: combinational table plus register/reset sequence.
module tb_fadd_a1_unit;

    logic        clk;
    logic        rst;
    logic [31:0] a, b, out, out_q;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          sym;
    } vec_t;

    localparam int N_VEC = 17;
    vec_t vecs [N_VEC];

    fadd_a1_unit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .out  (out),
        .out_q(out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, req);
    endtask

    initial begin
        vecs[0]  = '{"sub_norm_1",  32'hc9e2_abbb, 32'h49f7_aeb5, 32'h48d4_0be8, 1'b1};
        vecs[1]  = '{"sub_norm_2",  32'hc9c8_6b2c, 32'h49d8_5aad, 32'h487f_7c08, 1'b1};
        vecs[2]  = '{"carry",       32'h49e6_6679, 32'h49dc_49f1, 32'h4a61_5835, 1'b1};
        vecs[3]  = '{"unnorm_add",  32'h4a02_7533, 32'h4928_fa97, 32'h4a0c_b3d8, 1'b1};
        vecs[4]  = '{"mixed_sign",  32'h4928_fa97, 32'hca02_7533, 32'h4a07_c972, 1'b1};
        vecs[5]  = '{"zero_pp",     32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{"zero_pn",     32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{"zero_np",     32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[8]  = '{"zero_a",      32'h8000_0000, 32'hbfc0_0000, 32'hbfc0_0000, 1'b0};
        vecs[9]  = '{"zero_b",      32'h7f7f_ffff, 32'h0000_0000, 32'h7f7f_ffff, 1'b0};
        vecs[10] = '{"shift_out",   32'h3fc0_0000, 32'h7f7f_ffff, 32'h7f7f_ffff, 1'b1};
        vecs[11] = '{"ovf_pos",     32'h7f7f_ffff, 32'h7c7f_ffff, 32'h7fbf_0001, 1'b1};
        vecs[12] = '{"ovf_neg",     32'hff7f_ffff, 32'hfc7f_ffff, 32'hffbf_0001, 1'b1};
        vecs[13] = '{"cancel",      32'h4040_0000, 32'hc040_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{"underflow",   32'h80e0_0000, 32'h00d0_0000, 32'h8000_0000, 1'b1};
        vecs[15] = '{"align_d22",   32'h4b40_0000, 32'h407f_ffff, 32'h4b40_0001, 1'b1};
        vecs[16] = '{"align_d23",   32'h4b40_0000, 32'h3fff_ffff, 32'h4b40_0000, 1'b1};

        rst = 1'b1;
        a   = 32'h0;
        b   = 32'h0;
        #2;
        check("reset_out_q", out_q, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            #1;
            check({vecs[i].name, "_ab"}, out, vecs[i].exp);
            if (vecs[i].sym) begin
                a = vecs[i].b;
                b = vecs[i].a;
                #1;
                check({vecs[i].name, "_ba"}, out, vecs[i].exp);
            end
        end

        // Registered path: out_q follows out with one cycle of latency.
        @(negedge clk);
        a = 32'h49e6_6679;
        b = 32'h49dc_49f1;
        @(posedge clk);
        #1;
        check("reg_first", out_q, 32'h4a61_5835);
        @(negedge clk);
        a = 32'hc9e2_abbb;
        b = 32'h49f7_aeb5;
        #1;
        check("reg_hold", out_q, 32'h4a61_5835);
        @(posedge clk);
        #1;
        check("reg_second", out_q, 32'h48d4_0be8);

        // Asynchronous reset mid-cycle, held across an edge.
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", out_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_held", out_q, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        a   = 32'h7f7f_ffff;
        b   = 32'h7c7f_ffff;
        @(posedge clk);
        #1;
        check("reg_after_rst", out_q, 32'h7fbf_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
